// File: rtl/ab_log_pkg.sv
// Shared types and constants for the A/B edit event logger.
// An event record is {timestamp, ab_evt_t}; the timestamp width is set by the logger.
package ab_log_pkg;

    localparam int REF_W = 3;
    localparam logic [REF_W-1:0] NO_EDIT = 3'd0;

    typedef struct packed {
        logic [REF_W-1:0] ref_a;
        logic [REF_W-1:0] ref_b;
        logic             a_in;
        logic             b_in;
        logic             a_out;
        logic             b_out;
    } ab_evt_t;

    localparam int EVT_W = $bits(ab_evt_t);

    function automatic logic is_edit(input logic [REF_W-1:0] r);
        return r != NO_EDIT;
    endfunction

endpackage

// File: rtl/ab_log_fifo.sv
// Event record FIFO: unreset storage, wrap-bit pointers, registered-only read path.
// A push while full is accepted only when a pop happens in the same cycle.
module ab_log_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // When full, the write slot equals the head slot being popped this cycle.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ab_edit_event_logger.sv
// Logs cycles where either enforcement policy edits A/B into a FIFO with a timestamp,
// and keeps saturating edit/drop statistics plus a sticky overflow flag.
module ab_edit_event_logger
    import ab_log_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  A_ctp_in,
    input  logic                  B_ctp_in,
    input  logic                  A_ctp_out,
    input  logic                  B_ctp_out,
    input  logic [REF_W-1:0]      policy_a_recovery_ref,
    input  logic [REF_W-1:0]      policy_b_recovery_ref,
    input  logic                  clear_stats,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [TS_W+EVT_W-1:0] evt_data,
    output logic [CNT_W-1:0]      edits_a,
    output logic [CNT_W-1:0]      edits_b,
    output logic [CNT_W-1:0]      dropped,
    output logic                  overflow
);
    localparam logic [TS_W-1:0]  TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [TS_W-1:0] ts;
    ab_evt_t         rec;
    logic            edit_a;
    logic            edit_b;
    logic            is_evt;
    logic            full;
    logic            empty;
    logic            drop;

    assign edit_a = is_edit(policy_a_recovery_ref);
    assign edit_b = is_edit(policy_b_recovery_ref);
    assign is_evt = edit_a || edit_b;

    always_comb begin
        rec       = '0;
        rec.ref_a = policy_a_recovery_ref;
        rec.ref_b = policy_b_recovery_ref;
        rec.a_in  = A_ctp_in;
        rec.b_in  = B_ctp_in;
        rec.a_out = A_ctp_out;
        rec.b_out = B_ctp_out;
    end

    // A full FIFO still accepts the event if the head leaves in the same cycle.
    assign drop      = is_evt && full && !evt_ready;
    assign evt_valid = !empty;

    ab_log_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(TS_W + EVT_W)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (is_evt),
        .wr_data({ts, rec}),
        .full   (full),
        .pop    (evt_ready),
        .rd_data(evt_data),
        .empty  (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) ts <= '0;
        else        ts <= ts + TS_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear_stats) begin
            edits_a  <= '0;
            edits_b  <= '0;
            dropped  <= '0;
            overflow <= 1'b0;
        end else begin
            if (edit_a && (edits_a != '1)) edits_a <= edits_a + CNT_ONE;
            if (edit_b && (edits_b != '1)) edits_b <= edits_b + CNT_ONE;
            if (drop) begin
                if (dropped != '1) dropped <= dropped + CNT_ONE;
                overflow <= 1'b1;
            end
        end
    end

endmodule
